// File: rtl/fetch_pkg.sv
// Shared definitions for the cached fetch stage: FSM states, counter width
// and the address-field width helpers used by the top and the cache.
package fetch_pkg;

    typedef enum logic [1:0] {
        LOOKUP   = 2'd0,
        MISS_REQ = 2'd1,
        REFILL   = 2'd2
    } fetch_state_e;

    localparam int unsigned MISS_CNT_W = 16;

    // Word-offset field width (selects a 32-bit word within a line)
    function automatic int unsigned off_w(input int unsigned words_per_line);
        return $clog2(words_per_line);
    endfunction

    // Line-index field width
    function automatic int unsigned idx_w(input int unsigned lines);
        return $clog2(lines);
    endfunction

    // Tag field width: everything above index, offset and the byte bits
    function automatic int unsigned tag_w(input int unsigned addr_w,
                                          input int unsigned lines,
                                          input int unsigned words_per_line);
        return addr_w - idx_w(lines) - off_w(words_per_line) - 2;
    endfunction

endpackage

// File: rtl/fetch_unit_cached_if.sv
// Pipeline-side and memory-side signals of the fetch stage. The fetch unit
// is the slave; whatever drives redirects/stalls and serves refills is the master.
interface fetch_unit_cached_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned LINE_W = 128
);
    logic              Stall;
    logic              PCSrc;
    logic [ADDR_W-1:0] BranchTarget;
    logic [31:0]       Inst;
    logic [ADDR_W-1:0] PCPlus4;
    logic              InstValid;
    logic              Hit;
    logic              MemReq;
    logic [ADDR_W-1:0] MemAddr;
    logic              MemAck;
    logic [LINE_W-1:0] MemLine;
    logic [15:0]       MissCount;

    modport master (
        output Stall, PCSrc, BranchTarget, MemAck, MemLine,
        input  Inst, PCPlus4, InstValid, Hit, MemReq, MemAddr, MissCount
    );

    modport slave (
        input  Stall, PCSrc, BranchTarget, MemAck, MemLine,
        output Inst, PCPlus4, InstValid, Hit, MemReq, MemAddr, MissCount
    );
endinterface

// File: rtl/icache_dm.sv
// Direct-mapped instruction cache storage: combinational tag/valid compare
// and word select, one synchronous whole-line write port, valid bits cleared
// synchronously on reset (tags and data are left as-is).
module icache_dm
    import fetch_pkg::*;
#(
    parameter  int unsigned LINES          = 16,
    parameter  int unsigned WORDS_PER_LINE = 4,
    parameter  int unsigned TAG_W          = 24,
    localparam int unsigned IDX_W          = idx_w(LINES),
    localparam int unsigned OFF_W          = off_w(WORDS_PER_LINE),
    localparam int unsigned LINE_W         = 32 * WORDS_PER_LINE
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [IDX_W-1:0]  rd_idx_i,
    input  logic [TAG_W-1:0]  rd_tag_i,
    input  logic [OFF_W-1:0]  rd_off_i,
    output logic              hit_o,
    output logic [31:0]       word_o,
    input  logic              wr_en_i,
    input  logic [IDX_W-1:0]  wr_idx_i,
    input  logic [TAG_W-1:0]  wr_tag_i,
    input  logic [LINE_W-1:0] wr_line_i
);

    logic [LINES-1:0]  valid_q;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [LINE_W-1:0] data_q [LINES];
    logic [LINE_W-1:0] rd_line;

    // Valid bits: cleared on reset, set when a line is written
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
        end else if (wr_en_i) begin
            valid_q[wr_idx_i] <= 1'b1;
        end
    end

    // Tag and data arrays: written whole-line on refill
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            tag_q[wr_idx_i]  <= wr_tag_i;
            data_q[wr_idx_i] <= wr_line_i;
        end
    end

    // Read port: hit detect and word select for the current PC
    always_comb begin
        rd_line = data_q[rd_idx_i];
        hit_o   = valid_q[rd_idx_i] && (tag_q[rd_idx_i] == rd_tag_i);
        word_o  = rd_line[{rd_off_i, 5'b00000} +: 32];
    end

endmodule

// File: rtl/fetch_unit_cached.sv
// Instruction-fetch stage: PC register with redirect mux, direct-mapped L1
// I-cache, miss FSM refilling whole lines over a req/ack port, redirect
// latching during a miss, and a saturating miss counter.
module fetch_unit_cached
    import fetch_pkg::*;
#(
    parameter int unsigned       ADDR_W         = 32,
    parameter int unsigned       LINES          = 16,
    parameter int unsigned       WORDS_PER_LINE = 4,
    parameter logic [ADDR_W-1:0] RESET_PC       = '0
) (
    input logic                Clk,
    input logic                Rst,
    fetch_unit_cached_if.slave bus
);

    localparam int unsigned OFF_W  = off_w(WORDS_PER_LINE);
    localparam int unsigned IDX_W  = idx_w(LINES);
    localparam int unsigned TAG_W  = tag_w(ADDR_W, LINES, WORDS_PER_LINE);
    localparam int unsigned WPC_W  = ADDR_W - 2;
    localparam int unsigned LNUM_W = ADDR_W - 2 - OFF_W;

    // PC and redirect target are kept as word addresses; byte bits are always 0
    fetch_state_e       state_q, state_d;
    logic [WPC_W-1:0]   pcw_q, pcw_d;
    logic               pend_q, pend_d;
    logic [WPC_W-1:0]   pend_tgt_q, pend_tgt_d;
    logic [MISS_CNT_W-1:0] miss_cnt_q, miss_cnt_d;
    logic [LNUM_W-1:0]  line_q, line_d;

    logic [WPC_W-1:0]   tgt_w;
    logic               unused_tgt_lsbs;
    logic [OFF_W-1:0]   pc_off;
    logic [IDX_W-1:0]   pc_idx;
    logic [TAG_W-1:0]   pc_tag;
    logic               hit;
    logic [31:0]        word;
    logic               fill_en;

    assign tgt_w           = bus.BranchTarget[ADDR_W-1:2];
    assign unused_tgt_lsbs = ^bus.BranchTarget[1:0];
    assign pc_off          = pcw_q[OFF_W-1:0];
    assign pc_idx          = pcw_q[OFF_W +: IDX_W];
    assign pc_tag          = pcw_q[WPC_W-1 -: TAG_W];

    icache_dm #(
        .LINES          (LINES),
        .WORDS_PER_LINE (WORDS_PER_LINE),
        .TAG_W          (TAG_W)
    ) u_cache (
        .clk_i     (Clk),
        .rst_i     (Rst),
        .rd_idx_i  (pc_idx),
        .rd_tag_i  (pc_tag),
        .rd_off_i  (pc_off),
        .hit_o     (hit),
        .word_o    (word),
        .wr_en_i   (fill_en),
        .wr_idx_i  (pc_idx),
        .wr_tag_i  (pc_tag),
        .wr_line_i (bus.MemLine)
    );

    // State register and datapath registers
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q    <= LOOKUP;
            pcw_q      <= RESET_PC[ADDR_W-1:2];
            pend_q     <= 1'b0;
            pend_tgt_q <= '0;
            miss_cnt_q <= '0;
            line_q     <= '0;
        end else begin
            state_q    <= state_d;
            pcw_q      <= pcw_d;
            pend_q     <= pend_d;
            pend_tgt_q <= pend_tgt_d;
            miss_cnt_q <= miss_cnt_d;
            line_q     <= line_d;
        end
    end

    // Next-state, next-PC, redirect latch and counter update
    always_comb begin
        state_d    = state_q;
        pcw_d      = pcw_q;
        pend_d     = pend_q;
        pend_tgt_d = pend_tgt_q;
        miss_cnt_d = miss_cnt_q;
        line_d     = line_q;
        fill_en    = 1'b0;
        unique case (state_q)
            LOOKUP: begin
                if (bus.PCSrc) begin
                    pcw_d = tgt_w;
                end else if (!hit) begin
                    state_d = MISS_REQ;
                    line_d  = pcw_q[WPC_W-1:OFF_W];
                    if (miss_cnt_q != '1) begin
                        miss_cnt_d = miss_cnt_q + MISS_CNT_W'(1);
                    end
                end else if (!bus.Stall) begin
                    pcw_d = pcw_q + WPC_W'(1);
                end
            end
            MISS_REQ: begin
                if (bus.PCSrc) begin
                    pend_d     = 1'b1;
                    pend_tgt_d = tgt_w;
                end
                // Line is written on the ack edge, since MemLine is only
                // valid then; REFILL is the cycle in which it becomes visible.
                if (bus.MemAck) begin
                    fill_en = 1'b1;
                    state_d = REFILL;
                end
            end
            REFILL: begin
                state_d = LOOKUP;
                pend_d  = 1'b0;
                if (bus.PCSrc) begin
                    pcw_d = tgt_w;
                end else if (pend_q) begin
                    pcw_d = pend_tgt_q;
                end
            end
            default: begin
                state_d = LOOKUP;
            end
        endcase
    end

    // Pipeline and memory-port outputs
    always_comb begin
        bus.InstValid = (state_q == LOOKUP) && hit && !Rst;
        bus.Hit       = (state_q == LOOKUP) && hit && !Rst;
        bus.Inst      = word;
        bus.PCPlus4   = {pcw_q + WPC_W'(1), 2'b00};
        bus.MemReq    = (state_q == MISS_REQ);
        bus.MemAddr   = {line_q, {(OFF_W + 2){1'b0}}};
        bus.MissCount = miss_cnt_q;
    end

endmodule

// File: tb/tb_fetch_unit_cached.sv
// Randomized scoreboard bench for fetch_unit_cached: the expected instruction
// stream, miss counts and refill addresses come from a program-order model
// with an array-based direct-mapped cache; a monitor compares deliveries.
module tb_fetch_unit_cached;

    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned LINES    = 16;
    localparam int unsigned WPL      = 4;
    localparam int unsigned LINE_W   = 32 * WPL;
    localparam int unsigned LINE_B   = 4 * WPL;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic Clk = 1'b0;
    logic Rst = 1'b1;
    always #5 Clk = ~Clk;

    fetch_unit_cached_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus ();

    fetch_unit_cached #(
        .ADDR_W         (ADDR_W),
        .LINES          (LINES),
        .WORDS_PER_LINE (WPL),
        .RESET_PC       (RESET_PC)
    ) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic [31:0] pc;
        int unsigned misses;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] refill_q[$];
    int          checks = 0;
    int          errors = 0;
    int          deliveries = 0;

    int unsigned model_misses;
    logic [31:0] model_line [LINES];
    bit          model_valid [LINES];

    bit          snap_ok = 0;
    bit          snap_added;
    int unsigned snap_misses;
    logic [31:0] snap_line [LINES];
    bit          snap_valid [LINES];

    bit          mem_en = 0;
    bit          mem_busy = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [LINE_W-1:0] mk_line(input logic [31:0] base);
        logic [LINE_W-1:0] l;
        for (int i = 0; i < int'(WPL); i++) l[32*i +: 32] = mem_word(base + 32'(4 * i));
        return l;
    endfunction

    function automatic logic [31:0] pick_target();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0040;
            2:       return 32'h0000_0080;
            3:       return 32'h0000_0100;
            4:       return 32'h0000_03C0;
            default: return 32'($urandom_range(0, 255)) * 4;
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    // Next instruction in program order; a line absent from the model cache
    // costs one miss and one refill, after which the line is resident.
    task automatic push_fetch(input logic [31:0] pc, output bit added);
        int unsigned lnum, idx;
        exp_t e;
        lnum  = pc / LINE_B;
        idx   = lnum % LINES;
        added = 0;
        if (!model_valid[idx] || model_line[idx] != lnum) begin
            if (model_misses < 32'hFFFF) model_misses++;
            model_valid[idx] = 1;
            model_line[idx]  = lnum;
            refill_q.push_back(lnum * LINE_B);
            added = 1;
        end
        e.pc     = pc;
        e.misses = model_misses;
        exp_q.push_back(e);
    endtask

    task automatic model_reset();
        bit added;
        exp_q.delete();
        refill_q.delete();
        for (int i = 0; i < int'(LINES); i++) begin
            model_valid[i] = 0;
            model_line[i]  = '0;
        end
        model_misses = 0;
        snap_ok      = 0;
        push_fetch(RESET_PC, added);
    endtask

    // One cycle of stimulus, driven just after the rising edge
    task automatic step(input int unsigned stall_pct, input int unsigned br_pct);
        logic [31:0] tgt;
        bit added;
        if (!bus.MemReq) snap_ok = 0;
        bus.Stall = ($urandom_range(0, 99) < stall_pct);
        bus.PCSrc = 1'b0;
        if (bus.InstValid && exp_q.size() > 0) begin
            if ($urandom_range(0, 99) < br_pct) begin
                tgt = pick_target();
                bus.PCSrc        = 1'b1;
                bus.BranchTarget = tgt;
                push_fetch(tgt, added);
            end else if (!bus.Stall) begin
                push_fetch(exp_q[0].pc + 32'd4, added);
            end
        end else if (bus.MemReq && $urandom_range(0, 99) < br_pct) begin
            // A later redirect in the same miss replaces the earlier target,
            // so the earlier target's effect on the model is rolled back.
            tgt = pick_target();
            if (!snap_ok) begin
                snap_ok     = 1;
                snap_misses = model_misses;
                snap_line   = model_line;
                snap_valid  = model_valid;
            end else begin
                model_misses = snap_misses;
                model_line   = snap_line;
                model_valid  = snap_valid;
                if (snap_added && refill_q.size() > 0) void'(refill_q.pop_back());
            end
            bus.PCSrc        = 1'b1;
            bus.BranchTarget = tgt;
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            push_fetch(tgt, added);
            snap_added = added;
        end
        @(posedge Clk);
        #1;
    endtask

    // Monitor: compare each delivered instruction against the scoreboard head
    initial begin : monitor
        int idle;
        exp_t e;
        idle = 0;
        forever begin
            @(negedge Clk);
            if (bus.InstValid) begin
                idle = 0;
                if (exp_q.size() == 0) begin
                    check("unexpected_inst", 64'(bus.PCPlus4), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    e = exp_q[0];
                    check("inst",      64'(bus.Inst),      64'(mem_word(e.pc)));
                    check("pcplus4",   64'(bus.PCPlus4),   64'(e.pc + 32'd4));
                    check("misscount", 64'(bus.MissCount), 64'(e.misses));
                    check("hit",       64'(bus.Hit),       64'd1);
                    if (bus.PCSrc || !bus.Stall) begin
                        void'(exp_q.pop_front());
                        deliveries++;
                    end
                end
            end else if (!Rst && mem_en) begin
                idle++;
                if (idle > 80) begin
                    checks++;
                    errors++;
                    $display("FAIL delivery_timeout: got no InstValid for %0d cycles, required <= 80", idle);
                    idle = 0;
                end
            end
        end
    end

    // Memory model: random 0..3 cycle wait, checks refill address and its stability
    initial begin : memory
        int          wait_left;
        logic [31:0] hold_addr;
        logic [31:0] expa;
        wait_left = 0;
        hold_addr = '0;
        forever begin
            @(negedge Clk);
            if (mem_en) begin
                bus.MemAck = 1'b0;
                if (bus.MemReq) begin
                    if (!mem_busy) begin
                        mem_busy  = 1;
                        wait_left = $urandom_range(0, 3);
                        hold_addr = bus.MemAddr;
                        if (refill_q.size() == 0) begin
                            check("refill_unexpected", 64'(bus.MemAddr), 64'hFFFF_FFFF_FFFF_FFFF);
                        end else begin
                            expa = refill_q.pop_front();
                            check("memaddr", 64'(bus.MemAddr), 64'(expa));
                        end
                    end else begin
                        check("memaddr_stable", 64'(bus.MemAddr), 64'(hold_addr));
                    end
                    if (wait_left == 0) begin
                        bus.MemAck  = 1'b1;
                        bus.MemLine = mk_line(bus.MemAddr);
                        mem_busy    = 0;
                    end else begin
                        wait_left--;
                    end
                end
            end
        end
    end

    initial begin : stimulus
        int guard;
        bus.Stall        = 1'b0;
        bus.PCSrc        = 1'b0;
        bus.BranchTarget = '0;
        bus.MemAck       = 1'b0;
        bus.MemLine      = '0;
        Rst              = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        check("rst_memreq",    64'(bus.MemReq),    64'd0);
        check("rst_instvalid", 64'(bus.InstValid), 64'd0);
        check("rst_hit",       64'(bus.Hit),       64'd0);
        check("rst_misscount", 64'(bus.MissCount), 64'd0);
        check("rst_memaddr",   64'(bus.MemAddr),   64'd0);
        check("rst_pcplus4",   64'(bus.PCPlus4),   64'(RESET_PC + 32'd4));
        Rst = 1'b0;
        model_reset();
        mem_en = 1;

        repeat (20) step(0, 0);
        repeat (1500) step(20, 10);

        // Reset in the middle of a refill request, then a stray ack
        guard = 0;
        while (!bus.MemReq && guard < 100) begin
            step(0, 0);
            guard++;
        end
        check("wait_memreq", 64'(bus.MemReq), 64'd1);
        mem_en       = 0;
        mem_busy     = 0;
        bus.MemAck   = 1'b0;
        bus.Stall    = 1'b0;
        bus.PCSrc    = 1'b0;
        Rst          = 1'b1;
        @(posedge Clk);
        #1;
        Rst = 1'b0;
        check("midrst_memreq",    64'(bus.MemReq),    64'd0);
        check("midrst_instvalid", 64'(bus.InstValid), 64'd0);
        check("midrst_misscount", 64'(bus.MissCount), 64'd0);
        check("midrst_pcplus4",   64'(bus.PCPlus4),   64'(RESET_PC + 32'd4));
        model_reset();
        bus.MemAck  = 1'b1;
        bus.MemLine = '1;
        @(posedge Clk);
        #1;
        bus.MemAck = 1'b0;
        check("late_ack_memreq", 64'(bus.MemReq),    64'd1);
        check("late_ack_count",  64'(bus.MissCount), 64'd1);
        mem_en = 1;

        repeat (500) step(25, 12);
        repeat (60) step(0, 0);
        check("progress", 64'(deliveries > 500), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
